// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// operand width and iteration counter sizing.
package mul_pkg;

    localparam int WIDTH      = 64;
    localparam int ITERATIONS = 64;
    localparam int CNT_W      = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : mul_pkg

// File: rtl/bit_Adder.sv
// Ripple-carry adder with carry-in and carry-out, built one bit-slice per
// generate iteration.
module bit_Adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule : bit_Adder

// File: rtl/shift_add_multiplier.sv
// Unsigned 64x64 -> 128 multiplier: one conditional add and right shift per
// cycle over a fixed 64 steps, with valid/ready handshakes on both sides.
module shift_add_multiplier #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    import mul_pkg::*;

    generate
        if (WIDTH != 64) begin : g_width_check
            $error("shift_add_multiplier supports only WIDTH = 64");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

    state_t             state_q;
    logic [2*WIDTH:0]   p_q;
    logic [2*WIDTH:0]   p_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     hi_next;

    bit_Adder #(
        .WIDTH (WIDTH)
    ) u_step_adder (
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry-out lands in bit 128 before the shift, so nothing is ever lost.
    assign hi_next = p_q[0] ? {add_cout, add_sum} : p_q[2*WIDTH:WIDTH];
    assign p_d     = {1'b0, hi_next, p_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= a;
                        p_q        <= {{(WIDTH+1){1'b0}}, b};
                        cnt_q      <= '0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign product_lo = out_valid_q ? p_q[WIDTH-1:0]       : '0;
    assign product_hi = out_valid_q ? p_q[2*WIDTH-1:WIDTH] : '0;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: products, latency, backpressure,
// operand isolation and asynchronous reset during a calculation.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product_lo;
    logic [63:0] product_hi;

    int n_checks = 0;
    int n_fail   = 0;

    shift_add_multiplier #(
        .WIDTH (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, wait for the result, optionally stall,
    // optionally poke a second request mid-calculation, then drain.
    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp_lo, input logic [63:0] exp_hi,
                          input int stall, input int pulse_at);
        int cyc;
        logic [127:0] held;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        check({tag, "_busy"}, {127'd0, in_ready}, 128'd0);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            if (cyc == pulse_at) begin
                in_valid = 1'b1; a = 64'd9; b = 64'd9;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
            if (cyc == 10)
                check({tag, "_calc_zero"}, {product_hi, product_lo}, 128'd0);
        end
        check({tag, "_latency"}, 128'(cyc), 128'd64);
        check({tag, "_lo"}, {64'd0, product_lo}, {64'd0, exp_lo});
        check({tag, "_hi"}, {64'd0, product_hi}, {64'd0, exp_hi});
        held = {product_hi, product_lo};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_stall_data"}, {product_hi, product_lo}, held);
            check({tag, "_stall_flags"}, {126'd0, out_valid, in_ready}, {126'd0, 2'b10});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("op %s a=0x%0h b=0x%0h lo=0x%0h hi=0x%0h cycles=%0d", tag, av, bv, exp_lo, exp_hi, cyc);
        check({tag, "_drain_flags"}, {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
        check({tag, "_drain_zero"}, {product_hi, product_lo}, 128'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        check("reset_flags", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
        check("reset_zero", {product_hi, product_lo}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 64'd3, 64'd5, 64'd15, 64'd0, 0, -1);
        run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE, 0, -1);
        run_op("carry", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 64'd1, 0, -1);
        run_op("zero", 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 64'd0, 0, -1);
        run_op("square", 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
               64'h0000_0002_0000_0001, 64'd1, 0, -1);
        run_op("stall", 64'd11, 64'd13, 64'd143, 64'd0, 10, -1);
        run_op("isolate", 64'd7, 64'd6, 64'd42, 64'd0, 0, 20);

        // The poked request must not have been queued behind the first.
        repeat (5) @(posedge clk);
        #1;
        check("isolate_no_second", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});

        // Reset during step 30 must clear flags without a clock edge.
        @(negedge clk);
        a = 64'd123; b = 64'd456; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_flags", {126'd0, out_valid, in_ready}, {126'd0, 2'b01});
        check("rst_async_zero", {product_hi, product_lo}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 64'd7, 64'd6, 64'd42, 64'd0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_add_multiplier

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand width in bits; only 64 is supported and other values SHALL fail an elaboration-time check.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, 64 bits: unsigned multiplicand.
REQ-007 The block SHALL have port b, input, 64 bits: unsigned multiplier.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the product is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the product.
REQ-010 The block SHALL have port product_lo, output, 64 bits: product bits [63:0].
REQ-011 The block SHALL have port product_hi, output, 64 bits: product bits [127:64].

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 in_ready SHALL equal 1 in IDLE only; out_valid SHALL equal 1 in DONE only.
REQ-014 Accept happens at the rising edge where in_valid=1 and in_ready=1, which SHALL:
  - latch a as the multiplicand;
  - load the 129-bit partial register P = {65'b0, b};
  - clear the 7-bit iteration counter;
  - enter CALC.
REQ-015 Each CALC edge SHALL perform one shift-add step:
  - if P[0]=1: P[128:64] = P[127:64] + multiplicand, 65-bit result including carry-out; otherwise P[128:64] is unchanged;
  - then logical-shift all of P right by 1;
  - increment the counter.
REQ-016 The counter SHALL count exactly 64 steps, with no early termination. The edge completing step 64 SHALL enter DONE, so out_valid first rises 64 cycles after the accept edge.
REQ-017 In DONE, product_lo SHALL equal P[63:0] and product_hi SHALL equal P[127:64]; P[128] SHALL be 0 by construction.
REQ-018 Outputs in DONE SHALL hold stable while out_ready=0, with no limit on the stall length.
REQ-019 The edge in DONE with out_ready=1 SHALL return the FSM to IDLE.
REQ-020 New operands SHALL NOT be accepted in that same cycle, because in_ready=0 in DONE.
REQ-021 in_valid asserted during CALC or DONE SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-022 The a and b inputs SHALL be sampled only on the accept edge; later changes SHALL have no effect.
REQ-023 product_lo and product_hi SHALL be 0 whenever the FSM is not in DONE.
REQ-024 Arithmetic SHALL be unsigned modulo 2^128; no overflow is possible.

Reset
REQ-025 Assertion of rst SHALL, asynchronously and in any state including mid-CALC:
  - force the FSM to IDLE;
  - clear P, the multiplicand and the counter;
  - drive in_ready=1, out_valid=0, product_lo=0 and product_hi=0.
REQ-026 Any operation in flight at reset SHALL be discarded without producing a result.
REQ-027 The first accept after reset deassertion SHALL be possible on the first clock edge.

Structure
REQ-028 A shared package mul_pkg SHALL hold:
  - the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - WIDTH;
  - the iteration count 64;
  - the counter width 7.
REQ-029 The 64-bit step adder SHALL be one instance of the team's existing bit_Adder, with cin tied to 0 and cout forming P bit 128 of the sum.
REQ-030 No other sub-module SHALL be used; the FSM, counter and shift register SHALL be local.

Verification
REQ-031 Basic product and latency: a=3, b=5, accepted at cycle T -> product_lo=15 and product_hi=0, with out_valid rising at cycle T+64 exactly.
REQ-032 Maximum operands: a=b=0xFFFF_FFFF_FFFF_FFFF -> product_hi=0xFFFF_FFFF_FFFF_FFFE and product_lo=0x0000_0000_0000_0001.
REQ-033 Carry into the high word: a=0x8000_0000_0000_0000, b=2 -> product_hi=1 and product_lo=0. Zero operand: a=0, b=0xDEAD_BEEF_CAFE_F00D -> both outputs 0.
REQ-034 Backpressure: out_ready held 0 for 10 cycles after out_valid -> outputs are bit-stable and in_ready=0 throughout; with out_ready=1, IDLE and in_ready=1 follow on the next cycle.
REQ-035 Operand isolation: in_valid pulsed with a=9, b=9 during step 20 of an a=7, b=6 operation -> the result is 42 and the second request is not accepted.
REQ-036 Reset mid-operation: rst asserted during step 30 -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; after deassertion, a=7, b=6 -> product_lo=42 after 64 cycles.
